// File: rtl/param_merge_router.sv
// param_merge_router: merge-network node that gathers one partial-sum flit
// from every input enabled in INPUT_MASK, adds them, and presents the sum on
// output port OUTPUT_SEL through a registered valid/ready stage.
// Compile-time option: define MERGE_SAT_EN to saturate the sum to the signed
// DW-bit range. Without it, the sum wraps modulo 2^DW.
module param_merge_router #(
  parameter int              DW         = 16,
  parameter int              NPORT      = 5,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [NPORT-1:0] INPUT_MASK = {NPORT{1'b0}},
  parameter int              OUTPUT_SEL = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] data_i  [NPORT],
  input  logic          valid_i [NPORT],
  output logic          ready_o [NPORT],
  output logic [DW-1:0] data_o  [NPORT],
  output logic          valid_o [NPORT],
  input  logic          ready_i [NPORT],
  output logic [31:0]   merge_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = DW + $clog2(NPORT);
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);

  logic                 fire_s;
  logic                 out_ready_s;
  logic [NPORT-1:0]     avail_s;
  logic signed [DW-1:0] head_s [NPORT];
  logic signed [SW-1:0] sum_wide_s;
  logic [DW-1:0]        sum_s;
  logic [DW-1:0]        out_data_r;
  logic                 out_valid_r;
  logic [31:0]          merge_cnt_r;

  // Per-port input FIFOs; unmasked ports never accept and never block a merge.
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    if (INPUT_MASK[p]) begin : g_fifo
      logic [DW-1:0] mem_r [FIFO_DEPTH];
      logic [AW-1:0] wr_ptr_r;
      logic [AW-1:0] rd_ptr_r;
      logic [CW-1:0] cnt_r;
      logic          not_full_s;
      logic          push_s;

      // Ready depends on registered occupancy only, so a pop never re-opens a full FIFO early.
      assign not_full_s = (cnt_r != FULL_LVL);
      assign push_s     = valid_i[p] && not_full_s;
      assign ready_o[p] = not_full_s;
      assign avail_s[p] = (cnt_r != {CW{1'b0}});
      assign head_s[p]  = mem_r[rd_ptr_r];

      // Pointer and occupancy tracking; pointers wrap naturally since depth is a power of two.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wr_ptr_r <= {AW{1'b0}};
          rd_ptr_r <= {AW{1'b0}};
          cnt_r    <= {CW{1'b0}};
        end else begin
          if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
          end
          if (fire_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
          end
          case ({push_s, fire_s})
            2'b10:   cnt_r <= cnt_r + CW'(1'b1);
            2'b01:   cnt_r <= cnt_r - CW'(1'b1);
            default: cnt_r <= cnt_r;
          endcase
        end
      end

      // Flit storage; contents are don't-care until the occupancy counter covers them.
      always_ff @(posedge clk) begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= data_i[p];
        end
      end
    end else begin : g_off
      logic unused_in_s;
      assign unused_in_s = ^{valid_i[p], data_i[p]};
      assign ready_o[p]  = 1'b0;
      assign avail_s[p]  = 1'b1;
      assign head_s[p]   = {DW{1'b0}};
    end
  end

  assign out_ready_s = ready_i[OUTPUT_SEL];
  assign fire_s      = (INPUT_MASK != {NPORT{1'b0}}) && (&avail_s) &&
                       (!out_valid_r || out_ready_s);

  // Sign-extended sum of all FIFO heads; unmasked ports contribute zero.
  always_comb begin
    sum_wide_s = {SW{1'b0}};
    for (int p = 0; p < NPORT; p++) begin
      sum_wide_s = sum_wide_s + SW'(head_s[p]);
    end
  end

`ifdef MERGE_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Clamp the wide sum into the signed DW-bit range.
  always_comb begin
    if (sum_wide_s > SAT_MAX) begin
      sum_s = SAT_MAX[DW-1:0];
    end else if (sum_wide_s < SAT_MIN) begin
      sum_s = SAT_MIN[DW-1:0];
    end else begin
      sum_s = sum_wide_s[DW-1:0];
    end
  end
`else
  // Wrap the wide sum modulo 2^DW by keeping its low bits.
  always_comb begin
    sum_s = sum_wide_s[DW-1:0];
  end

  if (SW > DW) begin : g_wrap_hi
    logic unused_hi_s;
    assign unused_hi_s = ^sum_wide_s[SW-1:DW];
  end
`endif

  // Output register: load on a merge, otherwise drop valid once downstream takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
      merge_cnt_r <= 32'd0;
    end else if (fire_s) begin
      out_data_r  <= sum_s;
      out_valid_r <= 1'b1;
      merge_cnt_r <= merge_cnt_r + 32'd1;
    end else if (out_valid_r && out_ready_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Only the configured output port is driven; all others stay idle at zero.
  for (genvar q = 0; q < NPORT; q++) begin : g_out
    if (q == OUTPUT_SEL) begin : g_sel
      assign valid_o[q] = out_valid_r;
      assign data_o[q]  = out_data_r;
    end else begin : g_idle
      logic unused_ready_s;
      assign unused_ready_s = ready_i[q];
      assign valid_o[q]     = 1'b0;
      assign data_o[q]      = {DW{1'b0}};
    end
  end

  assign merge_cnt = merge_cnt_r;

endmodule

// File: tb/tb_param_merge_router.sv
`timescale 1ns/1ps
module tb_param_merge_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // Instance A: 3-input merge onto port 2
  logic [15:0] d_a [5];
  logic        v_a [5];
  logic        r_a [5];
  logic [15:0] do_a [5];
  logic        vo_a [5];
  logic        ri_a [5];
  logic [31:0] cnt_a;

  // Shared inputs for instances B (overflow), Z (mask 0), S (single input)
  logic [15:0] d_x [5];
  logic        v_x [5];
  logic        ri_x [5];
  logic        r_b [5], vo_b [5], r_z [5], vo_z [5], r_s [5], vo_s [5];
  logic [15:0] do_b [5], do_z [5], do_s [5];
  logic [31:0] cnt_b, cnt_z, cnt_s;

  wire [4:0] r_a_v  = {r_a[4], r_a[3], r_a[2], r_a[1], r_a[0]};
  wire [4:0] vo_a_v = {vo_a[4], vo_a[3], vo_a[2], vo_a[1], vo_a[0]};
  wire [4:0] r_b_v  = {r_b[4], r_b[3], r_b[2], r_b[1], r_b[0]};
  wire [4:0] r_s_v  = {r_s[4], r_s[3], r_s[2], r_s[1], r_s[0]};
  wire [4:0] r_z_v  = {r_z[4], r_z[3], r_z[2], r_z[1], r_z[0]};
  wire [4:0] vo_z_v = {vo_z[4], vo_z[3], vo_z[2], vo_z[1], vo_z[0]};

  param_merge_router #(.DW(16), .NPORT(5), .FIFO_DEPTH(4), .INPUT_MASK(5'b00111), .OUTPUT_SEL(2)) u_a (
    .clk(clk), .rstn(rstn), .data_i(d_a), .valid_i(v_a), .ready_o(r_a),
    .data_o(do_a), .valid_o(vo_a), .ready_i(ri_a), .merge_cnt(cnt_a));
  param_merge_router #(.DW(16), .NPORT(5), .FIFO_DEPTH(4), .INPUT_MASK(5'b00011), .OUTPUT_SEL(0)) u_b (
    .clk(clk), .rstn(rstn), .data_i(d_x), .valid_i(v_x), .ready_o(r_b),
    .data_o(do_b), .valid_o(vo_b), .ready_i(ri_x), .merge_cnt(cnt_b));
  param_merge_router #(.DW(16), .NPORT(5), .FIFO_DEPTH(4), .INPUT_MASK(5'b00000), .OUTPUT_SEL(0)) u_z (
    .clk(clk), .rstn(rstn), .data_i(d_x), .valid_i(v_x), .ready_o(r_z),
    .data_o(do_z), .valid_o(vo_z), .ready_i(ri_x), .merge_cnt(cnt_z));
  param_merge_router #(.DW(16), .NPORT(5), .FIFO_DEPTH(4), .INPUT_MASK(5'b10000), .OUTPUT_SEL(4)) u_s (
    .clk(clk), .rstn(rstn), .data_i(d_x), .valid_i(v_x), .ready_o(r_s),
    .data_o(do_s), .valid_o(vo_s), .ready_i(ri_x), .merge_cnt(cnt_s));

  int n_cmp = 0;
  int n_err = 0;
  int merges_a = 0;
  logic mon_x_en = 1'b0;

  logic [15:0] mq0 [$];
  logic [15:0] mq1 [$];
  logic [15:0] mq2 [$];
  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];
  logic [15:0] exp_s [$];

  logic signed [15:0] x0, x1, x2;
  logic [15:0] e_a, e_x;
  int s_a;

  function automatic logic [15:0] fv(int p, int k);
    return 16'(k * 37 - 100 + p * 11);
  endfunction

  // Model for instance A: record accepted flits, form sums in arrival order, check outputs.
  always @(negedge clk) begin
    if (rstn) begin
      if (v_a[0] && r_a[0]) mq0.push_back(d_a[0]);
      if (v_a[1] && r_a[1]) mq1.push_back(d_a[1]);
      if (v_a[2] && r_a[2]) mq2.push_back(d_a[2]);
      if (mq0.size() > 0 && mq1.size() > 0 && mq2.size() > 0) begin
        x0 = mq0.pop_front();
        x1 = mq1.pop_front();
        x2 = mq2.pop_front();
        s_a = int'(x0) + int'(x1) + int'(x2);
        exp_a.push_back(16'(s_a));
        merges_a++;
      end
      if (vo_a[2] && ri_a[2]) begin
        n_cmp++;
        if (exp_a.size() == 0) begin
          n_err++;
          $display("FAIL a_unexpected: got output %0d, required none", $signed(do_a[2]));
        end else begin
          e_a = exp_a.pop_front();
          if (do_a[2] !== e_a) begin
            n_err++;
            $display("FAIL a_sum: got %0d, required %0d", $signed(do_a[2]), $signed(e_a));
          end
        end
      end
    end
  end

  // Scoreboard checks for instances B (port 0) and S (port 4).
  always @(negedge clk) begin
    if (rstn && mon_x_en) begin
      if (vo_b[0] && ri_x[0]) begin
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_err++;
          $display("FAIL b_unexpected: got output %0d, required none", $signed(do_b[0]));
        end else begin
          e_x = exp_b.pop_front();
          if (do_b[0] !== e_x) begin
            n_err++;
            $display("FAIL b_sum: got %0d, required %0d", $signed(do_b[0]), $signed(e_x));
          end
        end
      end
      if (vo_s[4] && ri_x[4]) begin
        n_cmp++;
        if (exp_s.size() == 0) begin
          n_err++;
          $display("FAIL s_unexpected: got output %0d, required none", do_s[4]);
        end else begin
          e_x = exp_s.pop_front();
          if (do_s[4] !== e_x) begin
            n_err++;
            $display("FAIL s_pass: got %0d, required %0d", do_s[4], e_x);
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    for (int p = 0; p < 5; p++) begin
      d_a[p] = 16'h0000; v_a[p] = 1'b0; ri_a[p] = 1'b1;
      d_x[p] = 16'h0000; v_x[p] = 1'b0; ri_x[p] = 1'b1;
    end
  endtask

  task automatic clear_model();
    mq0.delete(); mq1.delete(); mq2.delete();
    exp_a.delete(); exp_b.delete(); exp_s.delete();
    merges_a = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    clear_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic set_a(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                       input logic [2:0] v);
    d_a[0] = a0; d_a[1] = a1; d_a[2] = a2;
    v_a[0] = v[0]; v_a[1] = v[1]; v_a[2] = v[2];
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (vo_a_v !== 5'b00000) begin n_err++; $display("FAIL reset_valid: got %b, required 00000", vo_a_v); end
    n_cmp++;
    if ((do_a[0] | do_a[1] | do_a[2] | do_a[3] | do_a[4]) !== 16'h0000) begin
      n_err++; $display("FAIL reset_data: got nonzero data_o, required all zero");
    end
    n_cmp++;
    if (cnt_a !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d, required 0", cnt_a); end
    n_cmp++;
    if (r_a_v !== 5'b00111) begin n_err++; $display("FAIL reset_ready_a: got %b, required 00111", r_a_v); end
    n_cmp++;
    if (r_b_v !== 5'b00011) begin n_err++; $display("FAIL reset_ready_b: got %b, required 00011", r_b_v); end
    n_cmp++;
    if (r_s_v !== 5'b10000) begin n_err++; $display("FAIL reset_ready_s: got %b, required 10000", r_s_v); end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    set_a(16'd100, 16'hFFE2, 16'd7, 3'b111);
    @(posedge clk); #1;
    set_a(16'd0, 16'd0, 16'd0, 3'b000);
    @(negedge clk);
    n_cmp++;
    if (vo_a[2] !== 1'b0) begin n_err++; $display("FAIL basic_early: got valid %b, required 0", vo_a[2]); end
    @(negedge clk);
    n_cmp++;
    if (vo_a_v !== 5'b00100) begin n_err++; $display("FAIL basic_valid: got %b, required 00100", vo_a_v); end
    n_cmp++;
    if (do_a[2] !== 16'd77) begin n_err++; $display("FAIL basic_data: got %0d, required 77", $signed(do_a[2])); end
    n_cmp++;
    if (cnt_a !== 32'd1) begin n_err++; $display("FAIL basic_cnt: got %0d, required 1", cnt_a); end
  endtask

  task automatic test_skew();
    @(posedge clk); #1;
    set_a(16'd10, 16'd0, 16'd20, 3'b101);
    @(posedge clk); #1;
    set_a(16'd0, 16'd0, 16'd0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (vo_a[2] !== 1'b0) begin n_err++; $display("FAIL skew_wait: cycle %0d got valid 1, required 0", i); end
    end
    @(posedge clk); #1;
    set_a(16'd0, 16'd5, 16'd0, 3'b010);
    @(posedge clk); #1;
    set_a(16'd0, 16'd0, 16'd0, 3'b000);
    @(negedge clk);
    n_cmp++;
    if (vo_a[2] !== 1'b0) begin n_err++; $display("FAIL skew_early: got valid 1, required 0"); end
    @(negedge clk);
    n_cmp++;
    if (vo_a[2] !== 1'b1 || do_a[2] !== 16'd35) begin
      n_err++; $display("FAIL skew_out: got valid %b data %0d, required valid 1 data 35", vo_a[2], $signed(do_a[2]));
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int hs = 0;
    @(posedge clk); #1;
    ri_a[2] = 1'b0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 12) ri_a[2] = 1'b1;
      if (acc < 10) set_a(fv(0, acc), fv(1, acc), fv(2, acc), 3'b111);
      else set_a(16'd0, 16'd0, 16'd0, 3'b000);
      @(negedge clk);
      if (v_a[0] && r_a[0]) acc++;
      if (cyc == 11) begin
        n_cmp++;
        if (acc !== 5) begin n_err++; $display("FAIL bp_accepted: got %0d, required 5", acc); end
        n_cmp++;
        if (r_a_v[2:0] !== 3'b000) begin n_err++; $display("FAIL bp_ready: got %b, required 000", r_a_v[2:0]); end
      end
      if (cyc == 12) begin
        n_cmp++;
        if (r_a[0] !== 1'b0) begin n_err++; $display("FAIL bp_pop_reopen: got ready 1, required 0"); end
      end
      if (cyc >= 12 && cyc < 22 && vo_a[2] && ri_a[2]) hs++;
    end
    n_cmp++;
    if (hs !== 10) begin n_err++; $display("FAIL bp_throughput: got %0d handshakes, required 10", hs); end
    n_cmp++;
    if (exp_a.size() !== 0) begin n_err++; $display("FAIL bp_drain: got %0d pending, required 0", exp_a.size()); end
    n_cmp++;
    if (cnt_a !== 32'(merges_a)) begin n_err++; $display("FAIL bp_cnt: got %0d, required %0d", cnt_a, merges_a); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ri_a[2] = 1'b0;
    set_a(16'd1, 16'd2, 16'd3, 3'b111);
    @(posedge clk); #1;
    set_a(16'd4, 16'd5, 16'd0, 3'b011);
    @(posedge clk); #1;
    set_a(16'd6, 16'd7, 16'd0, 3'b011);
    @(posedge clk); #1;
    set_a(16'd0, 16'd0, 16'd0, 3'b000);
    @(negedge clk);
    n_cmp++;
    if (vo_a[2] !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b, required 1", vo_a[2]); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (vo_a[2] !== 1'b0 || cnt_a !== 32'd0) begin
      n_err++; $display("FAIL mid_async: got valid %b cnt %0d, required valid 0 cnt 0", vo_a[2], cnt_a);
    end
    clear_model();
    ri_a[2] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    set_a(16'd10, 16'd20, 16'd30, 3'b111);
    @(posedge clk); #1;
    set_a(16'd0, 16'd0, 16'd0, 3'b000);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_a.size() !== 0 || cnt_a !== 32'd1) begin
      n_err++; $display("FAIL mid_after: got pending %0d cnt %0d, required 0 and 1", exp_a.size(), cnt_a);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    mon_x_en = 1'b1;
    @(posedge clk); #1;
    d_x[0] = 16'h7FFF; d_x[1] = 16'h0001; v_x[0] = 1'b1; v_x[1] = 1'b1;
`ifdef MERGE_SAT_EN
    exp_b.push_back(16'h7FFF);
`else
    exp_b.push_back(16'h8000);
`endif
    @(posedge clk); #1;
    d_x[0] = 16'h8000; d_x[1] = 16'hFFFF;
`ifdef MERGE_SAT_EN
    exp_b.push_back(16'h8000);
`else
    exp_b.push_back(16'h7FFF);
`endif
    @(posedge clk); #1;
    v_x[0] = 1'b0; v_x[1] = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_b.size() !== 0 || cnt_b !== 32'd2) begin
      n_err++; $display("FAIL ovf_done: got pending %0d cnt %0d, required 0 and 2", exp_b.size(), cnt_b);
    end
    mon_x_en = 1'b0;
  endtask

  task automatic test_mask_zero();
    do_reset();
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 5; p++) begin
        v_x[p]  = 1'($urandom_range(0, 1));
        d_x[p]  = 16'($urandom);
        ri_x[p] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n_cmp++;
      if ({r_z_v, vo_z_v} !== 10'b0) begin
        n_err++; $display("FAIL zero_mask: cycle %0d got ready %b valid %b, required 0", cyc, r_z_v, vo_z_v);
      end
    end
    n_cmp++;
    if (cnt_z !== 32'd0) begin n_err++; $display("FAIL zero_cnt: got %0d, required 0", cnt_z); end
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    mon_x_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      d_x[4] = 16'(k); v_x[4] = 1'b1;
      exp_s.push_back(16'(k));
    end
    @(posedge clk); #1;
    v_x[4] = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_s.size() !== 0 || cnt_s !== 32'd3) begin
      n_err++; $display("FAIL single_done: got pending %0d cnt %0d, required 0 and 3", exp_s.size(), cnt_s);
    end
    mon_x_en = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_basic();
    test_skew();
    test_backpressure();
    test_reset_mid();
    test_overflow();
    test_mask_zero();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
